mem_bist: RTL and testbench

Synthesizable built-in self-test engine for a single-port synchronous RAM with `read`/`write`/`addr`/`data_in`/`data_out` signalling. It generalises the 32x8 clear-and-check memory test:
- address and data widths are parametrised;
- four selectable data patterns;
- pipelined read compare with configurable read latency;
- error count and first-failing-address reporting.

It sits between the test controller (`start`/`mode` in, status out) and the memory under test.

---
 rtl/mem_bist.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_bist.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// mem_bist: built-in self-test engine for a single-port synchronous RAM.
// Writes a selectable pattern to every address, then reads every address
// back and compares through an RD_LAT-deep delay line.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, mode[1:0]    test request and pattern select (0 zeros, 1 address,
//                       2 checkerboard, 3 LFSR); accepted only when idle/done
//   read, write         memory strobes
//   addr, data_in       memory address and write data
//   data_out            memory read data, valid RD_LAT cycles after read
//   busy, done, pass    test status; pass is meaningful while done
//   err_count           saturating mismatch count
//   fail_addr           address of the first mismatch (0 if none)
//
// Optional build macro: MEM_BIST_INV_PASS_EN adds a second, bit-inverted
// write/read pass before done.
module mem_bist #(
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 8,
    parameter int          RD_LAT     = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                             r_state;
    logic [1:0]                         r_mode;
    logic [15:0]                        r_lfsr;
    logic [ADDR_WIDTH-1:0]              r_addr;
    logic [DATA_WIDTH-1:0]              r_data_in;
    logic                               r_read;
    logic                               r_write;
    logic                               r_busy;
    logic                               r_done;
    logic                               r_pass;
    logic [ADDR_WIDTH+1:0]              r_err_count;
    logic [ADDR_WIDTH-1:0]              r_fail_addr;
    logic [2:0]                         r_drain_cnt;

    // Stage 0 is loaded together with the read strobe; stage RD_LAT lines
    // up with the cycle in which data_out carries that read's data.
    logic [RD_LAT:0]                    r_pipe_vld;
    logic [RD_LAT:0][DATA_WIDTH-1:0]    r_pipe_exp;
    logic [RD_LAT:0][ADDR_WIDTH-1:0]    r_pipe_addr;

    logic                               w_inv;
    logic [2:0]                         w_drain_lim;
    logic                               w_mismatch;
    logic [ADDR_WIDTH+1:0]              w_err_next;
    logic [ADDR_WIDTH-1:0]              w_fail_next;
    logic [ADDR_WIDTH-1:0]              w_addr_inc;

`ifdef MEM_BIST_INV_PASS_EN
    logic                               r_inv;
    assign w_inv       = r_inv;
    // First pass drains one extra cycle before the inverted pass starts.
    assign w_drain_lim = r_inv ? 3'(RD_LAT - 1) : 3'(RD_LAT);
`else
    assign w_inv       = 1'b0;
    assign w_drain_lim = 3'(RD_LAT - 1);
`endif

    function automatic logic [15:0] f_lfsr_step(input logic [15:0] s);
        // Fibonacci LFSR, taps 16,14,13,11
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_pattern(
        input logic [1:0]            m,
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] lfsr_lo,
        input logic                  inv
    );
        logic [DATA_WIDTH-1:0] p;
        case (m)
            2'd0:    p = '0;
            2'd1:    p = DATA_WIDTH'(idx);
            2'd2:    p = DATA_WIDTH'(idx[0] ? 16'hAAAA : 16'h5555);
            default: p = lfsr_lo;
        endcase
        return p ^ {DATA_WIDTH{inv}};
    endfunction

    assign w_addr_inc = r_addr + ADDR_WIDTH'(1);

    always_comb begin
        w_mismatch  = r_pipe_vld[RD_LAT] && (data_out != r_pipe_exp[RD_LAT]);
        w_err_next  = r_err_count;
        w_fail_next = r_fail_addr;
        if (w_mismatch) begin
            if (r_err_count != '1) begin
                w_err_next = r_err_count + (ADDR_WIDTH + 2)'(1);
            end
            if (r_err_count == '0) begin
                w_fail_next = r_pipe_addr[RD_LAT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_lfsr      <= LFSR_SEED;
            r_addr      <= '0;
            r_data_in   <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_addr <= '0;
            r_drain_cnt <= '0;
            r_pipe_vld  <= '0;
            r_pipe_exp  <= '0;
            r_pipe_addr <= '0;
`ifdef MEM_BIST_INV_PASS_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_err_count   <= w_err_next;
            r_fail_addr   <= w_fail_next;
            r_pipe_vld[0] <= 1'b0;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_exp[k]  <= r_pipe_exp[k-1];
                r_pipe_addr[k] <= r_pipe_addr[k-1];
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WRITE;
                        r_mode      <= mode;
                        r_err_count <= '0;
                        r_fail_addr <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_write     <= 1'b1;
                        r_read      <= 1'b0;
                        r_addr      <= '0;
                        r_data_in   <= f_pattern(mode, '0, LFSR_SEED[DATA_WIDTH-1:0], 1'b0);
                        r_lfsr      <= f_lfsr_step(LFSR_SEED);
`ifdef MEM_BIST_INV_PASS_EN
                        r_inv       <= 1'b0;
`endif
                    end
                end

                S_WRITE: begin
                    if (r_addr == '1) begin
                        // Reloading the LFSR lets the read phase regenerate
                        // exactly the sequence that was written.
                        r_state        <= S_READ;
                        r_write        <= 1'b0;
                        r_read         <= 1'b1;
                        r_addr         <= '0;
                        r_pipe_vld[0]  <= 1'b1;
                        r_pipe_addr[0] <= '0;
                        r_pipe_exp[0]  <= f_pattern(r_mode, '0, LFSR_SEED[DATA_WIDTH-1:0], w_inv);
                        r_lfsr         <= f_lfsr_step(LFSR_SEED);
                    end else begin
                        r_addr    <= w_addr_inc;
                        r_data_in <= f_pattern(r_mode, w_addr_inc, r_lfsr[DATA_WIDTH-1:0], w_inv);
                        r_lfsr    <= f_lfsr_step(r_lfsr);
                    end
                end

                S_READ: begin
                    if (r_addr == '1) begin
                        r_state     <= S_DRAIN;
                        r_read      <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_addr         <= w_addr_inc;
                        r_pipe_vld[0]  <= 1'b1;
                        r_pipe_addr[0] <= w_addr_inc;
                        r_pipe_exp[0]  <= f_pattern(r_mode, w_addr_inc, r_lfsr[DATA_WIDTH-1:0], w_inv);
                        r_lfsr         <= f_lfsr_step(r_lfsr);
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == w_drain_lim) begin
`ifdef MEM_BIST_INV_PASS_EN
                        if (!r_inv) begin
                            r_state   <= S_WRITE;
                            r_inv     <= 1'b1;
                            r_write   <= 1'b1;
                            r_addr    <= '0;
                            r_data_in <= f_pattern(r_mode, '0, LFSR_SEED[DATA_WIDTH-1:0], 1'b1);
                            r_lfsr    <= f_lfsr_step(LFSR_SEED);
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end
`else
                        // The last compare retires on this same edge, so
                        // pass is taken from the next-state error count.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
`endif
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign read      = r_read;
    assign write     = r_write;
    assign addr      = r_addr;
    assign data_in   = r_data_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed self-checking bench for mem_bist.
// DUT A uses default parameters (32x8, RD_LAT 1) with a fault-injectable
// memory model; DUT B is 16x4 with RD_LAT 3.
module tb_mem_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // DUT A: defaults
    logic       a_start = 1'b0;
    logic [1:0] a_mode  = 2'd0;
    logic       a_read, a_write, a_busy, a_done, a_pass;
    logic [4:0] a_addr, a_fail;
    logic [7:0] a_din;
    logic [7:0] a_dout = 8'h00;
    logic [6:0] a_err;

    // DUT B: 16x4, RD_LAT 3
    logic       b_start = 1'b0;
    logic [1:0] b_mode  = 2'd0;
    logic       b_read, b_write, b_busy, b_done, b_pass;
    logic [3:0] b_addr, b_fail;
    logic [3:0] b_din;
    logic [3:0] b_dout = 4'h0;
    logic [5:0] b_err;

    mem_bist u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (a_start),
        .mode      (a_mode),
        .read      (a_read),
        .write     (a_write),
        .addr      (a_addr),
        .data_in   (a_din),
        .data_out  (a_dout),
        .busy      (a_busy),
        .done      (a_done),
        .pass      (a_pass),
        .err_count (a_err),
        .fail_addr (a_fail)
    );

    mem_bist #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (4),
        .RD_LAT     (3)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .mode      (b_mode),
        .read      (b_read),
        .write     (b_write),
        .addr      (b_addr),
        .data_in   (b_din),
        .data_out  (b_dout),
        .busy      (b_busy),
        .done      (b_done),
        .pass      (b_pass),
        .err_count (b_err),
        .fail_addr (b_fail)
    );

    // Memory model A with read-path fault injection
    logic [7:0] mem_a [0:31];
    logic [7:0] a_or_mask = 8'h00;
    int         a_bad     = -1;

    function automatic logic [7:0] fault_a(input logic [7:0] v, input logic [4:0] ad,
                                           input logic [7:0] orm, input int bad);
        logic [7:0] r;
        r = v | orm;
        if (int'(ad) == bad) r = ~r;
        return r;
    endfunction

    always @(posedge clk) begin
        if (a_write) mem_a[a_addr] <= a_din;
        if (a_read)  a_dout <= fault_a(mem_a[a_addr], a_addr, a_or_mask, a_bad);
    end

    // Memory model B, three-cycle read latency
    logic [3:0] mem_b [0:15];
    logic [3:0] b_p1 = 4'h0;
    logic [3:0] b_p2 = 4'h0;

    always @(posedge clk) begin
        if (b_write) mem_b[b_addr] <= b_din;
        if (b_read)  b_p1 <= mem_b[b_addr];
        b_p2   <= b_p1;
        b_dout <= b_p2;
    end

    // Strobe counters for the selected DUT
    bit sel = 1'b0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(posedge clk) begin
        if (sel ? b_write : a_write) wr_cnt <= wr_cnt + 1;
        if (sel ? b_read  : a_read)  rd_cnt <= rd_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [7:0] model_pat(input logic [1:0] m, input int i,
                                             input logic [15:0] l, input int dw);
        logic [7:0] p;
        logic [7:0] mask;
        case (m)
            2'd0:    p = 8'h00;
            2'd1:    p = i[7:0];
            2'd2:    p = i[0] ? 8'hAA : 8'h55;
            default: p = l[7:0];
        endcase
        mask = 8'((1 << dw) - 1);
        return p & mask;
    endfunction

    // Starts a test on DUT A (s=0) or B (s=1) and follows it to done,
    // recording the done cycle, strobe counts and write-data deviations.
    task automatic run_test(input bit s, input logic [1:0] m, input int pulse_at,
                            output int done_cyc, output int n_wr, output int n_rd,
                            output int n_wderr);
        int         w0, r0, idx, dw;
        logic [15:0] l;
        logic [7:0] obs_a, obs_d;
        logic       obs_wr, obs_done;
        sel = s;
        dw  = s ? 4 : 8;
        @(negedge clk);
        w0 = wr_cnt;
        r0 = rd_cnt;
        if (s) begin b_start = 1'b1; b_mode = m; end
        else   begin a_start = 1'b1; a_mode = m; end
        @(negedge clk);
        a_start  = 1'b0;
        b_start  = 1'b0;
        idx      = 0;
        l        = 16'hACE1;
        done_cyc = -1;
        n_wderr  = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == pulse_at) begin
                if (s) begin b_start = 1'b1; b_mode = 2'd3; end
                else   begin a_start = 1'b1; a_mode = 2'd3; end
            end else begin
                a_start = 1'b0;
                b_start = 1'b0;
            end
            obs_a    = s ? {4'h0, b_addr} : {3'h0, a_addr};
            obs_d    = s ? {4'h0, b_din}  : a_din;
            obs_wr   = s ? b_write : a_write;
            obs_done = s ? b_done  : a_done;
            if (obs_wr) begin
                if (obs_a != idx[7:0] || obs_d != model_pat(m, idx, l, dw)) n_wderr++;
                idx++;
                l = lfsr_next(l);
            end
            if (obs_done) begin
                done_cyc = n + 1;
                break;
            end
            @(negedge clk);
        end
        a_start = 1'b0;
        b_start = 1'b0;
        n_wr = wr_cnt - w0;
        n_rd = rd_cnt - r0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        n_tests++; if (a_read !== 1'b0)  begin n_fail++; $display("FAIL rst_read got=%b exp=0", a_read); end
        n_tests++; if (a_write !== 1'b0) begin n_fail++; $display("FAIL rst_write got=%b exp=0", a_write); end
        n_tests++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin
            n_fail++; $display("FAIL rst_status got=%b%b%b exp=000", a_busy, a_done, a_pass); end
        n_tests++; if (a_addr !== 5'd0 || a_din !== 8'd0) begin
            n_fail++; $display("FAIL rst_bus got=%h/%h exp=00/00", a_addr, a_din); end
        n_tests++; if (a_err !== 7'd0 || a_fail !== 5'd0) begin
            n_fail++; $display("FAIL rst_err got=%0d/%0d exp=0/0", a_err, a_fail); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zeros;
        int dc, nw, nr, wd;
        a_or_mask = 8'h00; a_bad = -1;
        run_test(1'b0, 2'd0, -1, dc, nw, nr, wd);
        n_tests++; if (dc != 66) begin n_fail++; $display("FAIL t1_done_cycle got=%0d exp=66", dc); end
        n_tests++; if (a_pass !== 1'b1) begin n_fail++; $display("FAIL t1_pass got=%b exp=1", a_pass); end
        n_tests++; if (a_err !== 7'd0 || a_fail !== 5'd0) begin
            n_fail++; $display("FAIL t1_err got=%0d/%0d exp=0/0", a_err, a_fail); end
        n_tests++; if (nw != 32 || nr != 32) begin
            n_fail++; $display("FAIL t1_strobes got=%0d/%0d exp=32/32", nw, nr); end
        n_tests++; if (wd != 0) begin n_fail++; $display("FAIL t1_wrdata got=%0d bad writes exp=0", wd); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_addr_stuck;
        int dc, nw, nr, wd;
        a_or_mask = 8'h08; a_bad = -1;
        run_test(1'b0, 2'd1, -1, dc, nw, nr, wd);
        n_tests++; if (dc != 66) begin n_fail++; $display("FAIL t2_done_cycle got=%0d exp=66", dc); end
        n_tests++; if (a_err !== 7'd16) begin n_fail++; $display("FAIL t2_err got=%0d exp=16", a_err); end
        n_tests++; if (a_fail !== 5'd0) begin n_fail++; $display("FAIL t2_fail_addr got=%0d exp=0", a_fail); end
        n_tests++; if (a_pass !== 1'b0) begin n_fail++; $display("FAIL t2_pass got=%b exp=0", a_pass); end
        n_tests++; if (wd != 0) begin n_fail++; $display("FAIL t2_wrdata got=%0d bad writes exp=0", wd); end
        a_or_mask = 8'h00;
    endtask

    task automatic test_checker_lat3;
        int dc, nw, nr, wd;
        run_test(1'b1, 2'd2, -1, dc, nw, nr, wd);
        n_tests++; if (dc != 36) begin n_fail++; $display("FAIL t3_done_cycle got=%0d exp=36", dc); end
        n_tests++; if (b_pass !== 1'b1 || b_err !== 6'd0) begin
            n_fail++; $display("FAIL t3_pass got=%b err=%0d exp=1 err=0", b_pass, b_err); end
        n_tests++; if (nw != 16 || nr != 16) begin
            n_fail++; $display("FAIL t3_strobes got=%0d/%0d exp=16/16", nw, nr); end
        n_tests++; if (wd != 0) begin n_fail++; $display("FAIL t3_wrdata got=%0d bad writes exp=0", wd); end
        sel = 1'b0;
    endtask

    task automatic test_lfsr_corrupt;
        int dc, nw, nr, wd;
        a_or_mask = 8'h00; a_bad = 31;
        run_test(1'b0, 2'd3, -1, dc, nw, nr, wd);
        n_tests++; if (dc != 66) begin n_fail++; $display("FAIL t4_done_cycle got=%0d exp=66", dc); end
        n_tests++; if (a_err !== 7'd1) begin n_fail++; $display("FAIL t4_err got=%0d exp=1", a_err); end
        n_tests++; if (a_fail !== 5'd31) begin n_fail++; $display("FAIL t4_fail_addr got=%0d exp=31", a_fail); end
        n_tests++; if (a_pass !== 1'b0) begin n_fail++; $display("FAIL t4_pass got=%b exp=0", a_pass); end
        n_tests++; if (wd != 0) begin n_fail++; $display("FAIL t4_wrdata got=%0d bad writes exp=0", wd); end
        a_bad = -1;
    endtask

    task automatic test_reset_mid;
        bit found;
        int w0, r0, dc, nw, nr, wd;
        sel = 1'b0;
        @(negedge clk);
        a_start = 1'b1; a_mode = 2'd0;
        @(negedge clk);
        a_start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (a_read && a_addr == 5'd7) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL t5_reach_read7 got=0 exp=1"); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (a_read !== 1'b0 || a_write !== 1'b0) begin
            n_fail++; $display("FAIL t5_strobe_drop got=%b%b exp=00", a_read, a_write); end
        n_tests++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fail++; $display("FAIL t5_status got=%b%b exp=00", a_busy, a_done); end
        w0 = wr_cnt; r0 = rd_cnt;
        repeat (3) @(negedge clk);
        n_tests++; if (wr_cnt != w0 || rd_cnt != r0) begin
            n_fail++; $display("FAIL t5_no_strobes got=%0d exp=0", (wr_cnt - w0) + (rd_cnt - r0)); end
        rst = 1'b0;
        run_test(1'b0, 2'd0, -1, dc, nw, nr, wd);
        n_tests++; if (dc != 66 || a_pass !== 1'b1) begin
            n_fail++; $display("FAIL t5_rerun got=cyc %0d pass %b exp=cyc 66 pass 1", dc, a_pass); end
    endtask

    task automatic test_restart_ignored;
        int dc, nw, nr, wd;
        run_test(1'b0, 2'd0, 10, dc, nw, nr, wd);
        n_tests++; if (dc != 66) begin n_fail++; $display("FAIL t6_done_cycle got=%0d exp=66", dc); end
        n_tests++; if (nw + nr != 64) begin n_fail++; $display("FAIL t6_strobes got=%0d exp=64", nw + nr); end
        n_tests++; if (wd != 0) begin n_fail++; $display("FAIL t6_wrdata got=%0d bad writes exp=0", wd); end
        n_tests++; if (a_pass !== 1'b1) begin n_fail++; $display("FAIL t6_pass got=%b exp=1", a_pass); end
    endtask

    initial begin
        test_reset;
        test_zeros;
        test_addr_stuck;
        test_checker_lat3;
        test_lfsr_corrupt;
        test_reset_mid;
        test_restart_ignored;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
